control_seq: RTL and testbench
==============================

Name: control_seq

Overview:
- Parametrised successor to the CPU control FSM.
- Mealy sequencer: FETCH -> DECODE -> multi-cycle EXECUTE, with an optional memory wait state, branch-aware fetch control and a halt state.
- Sits between fetch unit, decode, register file and memory. Execute length and memory use are supplied per instruction by decode.

Parameters:
- STEP_W, 3, width of execute step counter; one instruction runs at most 2^STEP_W execute cycles.
- CNT_W, 16, width of retired-instruction counter (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst_async_n  in  1  asynchronous active-low reset.
- fetch_complete  in  1  fetch unit has an instruction word ready.
- exec_len  in  STEP_W  execute cycles minus 1; sampled in DECODE.
- exec_mem  in  1  instruction ends with a memory access; sampled in DECODE.
- mem_ready  in  1  memory access complete.
- branch_taken  in  1  PC redirect; sampled on last EXECUTE cycle.
- halt_req  in  1  request to stop at the next instruction boundary.
- state  out  3  current state: FETCH=0, DECODE=1, EXECUTE=2, MEM_WAIT=3, HALT=4.
- exec_step  out  STEP_W  current execute step, 0-based.
- decode_en  out  1  decode latches the instruction.
- rf_write_en  out  1  register file write strobe.
- mem_access_en  out  1  memory access in progress.
- fetch_operation  out  2  00 NOP, 01 INC_PC, 10 LOAD_PC; 11 is never driven.
- retire  out  1  one-cycle pulse when an instruction completes.
- halted  out  1  high while in HALT.

Behaviour:
- Reset (rst_async_n=0, takes effect immediately):
  - state=FETCH; exec_step=0; latched len/mem regs=0.
  - Every output other than state/exec_step reads 0 during reset.
  - Reset mid-instruction abandons it; no retire is issued.
- Outputs are combinational from state, latched regs and current inputs. Outputs are never X; unused values drive 0.
- FETCH:
  - halt_req=1 -> HALT. halt_req has priority over fetch_complete; decode_en=0.
  - Else if fetch_complete=1 -> DECODE, decode_en=1.
  - Else stay.
- DECODE:
  - Always 1 cycle; latch len_q<=exec_len, mem_q<=exec_mem; exec_step<=0.
  - Next state EXECUTE.
- EXECUTE:
  - exec_step increments by 1 each cycle while exec_step!=len_q.
  - Last step (exec_step==len_q), mem_q=0: rf_write_en=1, retire=1, fetch_operation = branch_taken ? LOAD_PC : INC_PC, -> FETCH.
  - Last step, mem_q=1: -> MEM_WAIT, fetch_operation=NOP.
  - Non-last steps: fetch_operation=NOP, rf_write_en=0.
  - exec_step never wraps: len_q=2^STEP_W-1 gives exactly 2^STEP_W cycles. len_q=0 gives exactly one cycle.
- MEM_WAIT:
  - mem_access_en=1 every cycle.
  - When mem_ready=1 (including the first cycle): rf_write_en=1, retire=1, fetch_operation=INC_PC, -> FETCH.
  - branch_taken is ignored. No timeout; waits indefinitely.
- HALT:
  - halted=1; all strobes 0.
  - halt_req=0 -> FETCH; next instruction proceeds normally.
- halt_req outside FETCH/HALT is ignored until the next FETCH; an in-flight instruction always completes.
- Minimum throughput: fetch_complete already high and exec_len=0 -> 3 cycles per instruction (FETCH, DECODE, EXECUTE).
- exec_step holds its value outside EXECUTE; it is reset to 0 in DECODE.

Optional Feature:
- Macro CONTROL_SEQ_RETIRE_CNT_EN.
- Defined:
  - Adds output retire_count (CNT_W, out), reset to 0, +1 on each retire pulse.
  - Wraps modulo 2^CNT_W.
  - Frozen (holds) while in HALT.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset with rst_async_n low mid-EXECUTE (exec_len=5, step 2) -> state=0, exec_step=0 and all strobes 0 immediately, before the next clk edge; no retire pulse.
- fetch_complete=1 held, exec_len=0, exec_mem=0, branch_taken=0 -> state sequence 0,1,2 repeating; retire, rf_write_en and fetch_operation=01 pulse every 3rd cycle.
- exec_len=7 (STEP_W=3), branch_taken=1 on last step -> exec_step counts 0..7 across 8 EXECUTE cycles; fetch_operation=10 only on step 7; no wrap.
- exec_mem=1, exec_len=1, mem_ready held low 4 cycles after MEM_WAIT entry then high -> mem_access_en high 5 cycles; single rf_write_en/retire on the mem_ready cycle, then state=0.
- halt_req raised during EXECUTE -> instruction retires, then HALT with halted=1 and fetch_complete ignored. halt_req dropped -> FETCH next cycle. Also: halt_req and fetch_complete high together in FETCH -> HALT, decode_en=0.
- With CONTROL_SEQ_RETIRE_CNT_EN and CNT_W=4 -> 17 retired instructions give retire_count=1; count unchanged across HALT.

Source files
------------

// File: rtl/control_seq.sv
// Mealy control sequencer: FETCH -> DECODE -> multi-cycle EXECUTE, optional MEM_WAIT, HALT.
// Optional retired-instruction counter enabled by `define CONTROL_SEQ_RETIRE_CNT_EN.
module control_seq #(
    parameter int STEP_W = 3
`ifdef CONTROL_SEQ_RETIRE_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_async_n,
    input  logic              fetch_complete,
    input  logic [STEP_W-1:0] exec_len,
    input  logic              exec_mem,
    input  logic              mem_ready,
    input  logic              branch_taken,
    input  logic              halt_req,
    output logic [2:0]        state,
    output logic [STEP_W-1:0] exec_step,
    output logic              decode_en,
    output logic              rf_write_en,
    output logic              mem_access_en,
    output logic [1:0]        fetch_operation,
    output logic              retire,
`ifdef CONTROL_SEQ_RETIRE_CNT_EN
    output logic [CNT_W-1:0]  retire_count,
`endif
    output logic              halted
);

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXECUTE  = 3'd2,
        S_MEM_WAIT = 3'd3,
        S_HALT     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        FOP_NOP     = 2'b00,
        FOP_INC_PC  = 2'b01,
        FOP_LOAD_PC = 2'b10
    } fop_t;

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] len_q;
    logic              mem_q;
    logic              last_step;
    fop_t              fop;

    assign last_step = (step_q == len_q);

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            state_q <= S_FETCH;
            step_q  <= '0;
            len_q   <= '0;
            mem_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                len_q  <= exec_len;
                mem_q  <= exec_mem;
                step_q <= '0;
            end else if (state_q == S_EXECUTE && !last_step) begin
                step_q <= step_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        decode_en     = 1'b0;
        rf_write_en   = 1'b0;
        mem_access_en = 1'b0;
        fop           = FOP_NOP;
        retire        = 1'b0;
        halted        = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (halt_req) begin
                    state_d = S_HALT;
                end else if (fetch_complete) begin
                    state_d   = S_DECODE;
                    decode_en = 1'b1;
                end
            end
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                if (last_step) begin
                    if (mem_q) begin
                        state_d = S_MEM_WAIT;
                    end else begin
                        rf_write_en = 1'b1;
                        retire      = 1'b1;
                        fop         = branch_taken ? FOP_LOAD_PC : FOP_INC_PC;
                        state_d     = S_FETCH;
                    end
                end
            end
            S_MEM_WAIT: begin
                mem_access_en = 1'b1;
                if (mem_ready) begin
                    rf_write_en = 1'b1;
                    retire      = 1'b1;
                    fop         = FOP_INC_PC;
                    state_d     = S_FETCH;
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (!halt_req) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // FETCH strobes depend on live inputs, so force them quiet while reset is held
        if (!rst_async_n) begin
            decode_en     = 1'b0;
            rf_write_en   = 1'b0;
            mem_access_en = 1'b0;
            fop           = FOP_NOP;
            retire        = 1'b0;
            halted        = 1'b0;
        end
    end

    assign state           = state_q;
    assign exec_step       = step_q;
    assign fetch_operation = fop;

`ifdef CONTROL_SEQ_RETIRE_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            cnt_q <= '0;
        end else if (retire && state_q != S_HALT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign retire_count = cnt_q;
`endif

endmodule

// File: tb/tb_control_seq.sv
// Directed self-checking bench for control_seq; retire counter checks run when
// CONTROL_SEQ_RETIRE_CNT_EN is defined.
module tb_control_seq;

    logic       clk = 1'b0;
    logic       rst_async_n;
    logic       fetch_complete;
    logic [2:0] exec_len;
    logic       exec_mem;
    logic       mem_ready;
    logic       branch_taken;
    logic       halt_req;
    logic [2:0] state;
    logic [2:0] exec_step;
    logic       decode_en;
    logic       rf_write_en;
    logic       mem_access_en;
    logic [1:0] fetch_operation;
    logic       retire;
    logic       halted;
`ifdef CONTROL_SEQ_RETIRE_CNT_EN
    logic [3:0] retire_count;
`endif

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    control_seq #(
        .STEP_W(3)
`ifdef CONTROL_SEQ_RETIRE_CNT_EN
        , .CNT_W(4)
`endif
    ) dut (
        .clk            (clk),
        .rst_async_n    (rst_async_n),
        .fetch_complete (fetch_complete),
        .exec_len       (exec_len),
        .exec_mem       (exec_mem),
        .mem_ready      (mem_ready),
        .branch_taken   (branch_taken),
        .halt_req       (halt_req),
        .state          (state),
        .exec_step      (exec_step),
        .decode_en      (decode_en),
        .rf_write_en    (rf_write_en),
        .mem_access_en  (mem_access_en),
        .fetch_operation(fetch_operation),
        .retire         (retire),
`ifdef CONTROL_SEQ_RETIRE_CNT_EN
        .retire_count   (retire_count),
`endif
        .halted         (halted)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input int exp);
        total++;
        assert (obs === 16'(exp)) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_strobes(input string tag, input int dec, input int rf, input int mem,
                               input int fop, input int ret, input int hlt);
        chk({tag, ".decode_en"}, 16'(decode_en), dec);
        chk({tag, ".rf_write_en"}, 16'(rf_write_en), rf);
        chk({tag, ".mem_access_en"}, 16'(mem_access_en), mem);
        chk({tag, ".fetch_operation"}, 16'(fetch_operation), fop);
        chk({tag, ".retire"}, 16'(retire), ret);
        chk({tag, ".halted"}, 16'(halted), hlt);
    endtask

    initial begin
        rst_async_n    = 1'b0;
        fetch_complete = 1'b0;
        exec_len       = 3'd0;
        exec_mem       = 1'b0;
        mem_ready      = 1'b0;
        branch_taken   = 1'b0;
        halt_req       = 1'b0;

        // reset state
        #2;
        chk("rst.state", 16'(state), 0);
        chk("rst.exec_step", 16'(exec_step), 0);
        chk_strobes("rst", 0, 0, 0, 0, 0, 0);
        tick();
        rst_async_n = 1'b1;

        // back-to-back single-cycle instructions
        fetch_complete = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("thru%0d.state", i), 16'(state), i % 3);
            chk_strobes($sformatf("thru%0d", i), (i % 3 == 0) ? 1 : 0, (i % 3 == 2) ? 1 : 0, 0,
                        (i % 3 == 2) ? 1 : 0, (i % 3 == 2) ? 1 : 0, 0);
            tick();
        end

        // full-length execute with branch on last step
        exec_len     = 3'd7;
        branch_taken = 1'b1;
        #1;
        chk("long.fetch_state", 16'(state), 0);
        tick();
        fetch_complete = 1'b0;
        #1;
        chk("long.decode_state", 16'(state), 1);
        tick();
        for (int s = 0; s < 8; s++) begin
            #1;
            chk($sformatf("long%0d.state", s), 16'(state), 2);
            chk($sformatf("long%0d.exec_step", s), 16'(exec_step), s);
            chk($sformatf("long%0d.fop", s), 16'(fetch_operation), (s == 7) ? 2 : 0);
            chk($sformatf("long%0d.retire", s), 16'(retire), (s == 7) ? 1 : 0);
            tick();
        end
        branch_taken = 1'b0;
        #1;
        chk("long.after_state", 16'(state), 0);
        chk("long.step_hold", 16'(exec_step), 7);
        chk("long.idle_decode_en", 16'(decode_en), 0);
        tick();
        chk("long.idle_state", 16'(state), 0);

        // memory instruction with 4 wait cycles; branch_taken must be ignored there
        fetch_complete = 1'b1;
        exec_len       = 3'd1;
        exec_mem       = 1'b1;
        tick();
        fetch_complete = 1'b0;
        #1;
        chk("mem.decode_state", 16'(state), 1);
        tick();
        #1;
        chk("mem.ex0_step", 16'(exec_step), 0);
        chk_strobes("mem.ex0", 0, 0, 0, 0, 0, 0);
        tick();
        #1;
        chk("mem.ex1_step", 16'(exec_step), 1);
        chk_strobes("mem.ex1", 0, 0, 0, 0, 0, 0);
        tick();
        branch_taken = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("mem.wait%0d.state", k), 16'(state), 3);
            chk_strobes($sformatf("mem.wait%0d", k), 0, 0, 1, 0, 0, 0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("mem.ready_state", 16'(state), 3);
        chk_strobes("mem.ready", 0, 1, 1, 1, 1, 0);
        tick();
        mem_ready    = 1'b0;
        branch_taken = 1'b0;
        exec_mem     = 1'b0;
        #1;
        chk("mem.done_state", 16'(state), 0);
        chk("mem.done_mem_access", 16'(mem_access_en), 0);

        // halt requested mid-instruction, then halt/fetch together in FETCH
        fetch_complete = 1'b1;
        tick();
        tick();
        halt_req = 1'b1;
        #1;
        chk("halt.ex0_state", 16'(state), 2);
        chk("halt.ex0_retire", 16'(retire), 0);
        tick();
        #1;
        chk("halt.ex1_state", 16'(state), 2);
        chk_strobes("halt.ex1", 0, 1, 0, 1, 1, 0);
        tick();
        #1;
        chk("halt.fetch_state", 16'(state), 0);
        chk("halt.fetch_decode_en", 16'(decode_en), 0);
        tick();
        for (int h = 0; h < 2; h++) begin
            #1;
            chk($sformatf("halt%0d.state", h), 16'(state), 4);
            chk_strobes($sformatf("halt%0d", h), 0, 0, 0, 0, 0, 1);
            tick();
        end
        halt_req = 1'b0;
        #1;
        chk("halt.release_state", 16'(state), 4);
        tick();
        #1;
        chk("halt.resume_state", 16'(state), 0);
        chk("halt.resume_decode_en", 16'(decode_en), 1);
        chk("halt.resume_halted", 16'(halted), 0);

        // asynchronous reset at step 2 of a 6-cycle execute
        exec_len = 3'd5;
        tick();
        tick();
        tick();
        tick();
        chk("areset.pre_state", 16'(state), 2);
        chk("areset.pre_step", 16'(exec_step), 2);
        #1;
        rst_async_n = 1'b0;
        #1;
        chk("areset.state", 16'(state), 0);
        chk("areset.exec_step", 16'(exec_step), 0);
        chk_strobes("areset", 0, 0, 0, 0, 0, 0);
        tick();
        chk("areset.held_state", 16'(state), 0);
        chk("areset.held_retire", 16'(retire), 0);
        rst_async_n = 1'b1;

`ifdef CONTROL_SEQ_RETIRE_CNT_EN
        chk("cnt.reset", 16'(retire_count), 0);
        exec_len = 3'd0;
        repeat (51) tick();
        chk("cnt.wrap17", 16'(retire_count), 1);
        halt_req = 1'b1;
        tick();
        repeat (3) tick();
        chk("cnt.halt_state", 16'(state), 4);
        chk("cnt.halt_hold", 16'(retire_count), 1);
        halt_req = 1'b0;
        tick();
        chk("cnt.resume_state", 16'(state), 0);
        chk("cnt.resume_hold", 16'(retire_count), 1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
